// File: rtl/main_memory_arbiter_if.sv
// Bundle of the two requester ports and the main memory port.
//   slave  : the arbiter (takes requests and memory responses, drives strobes and completions)
//   master : the environment (requesters and memory)
interface main_memory_arbiter_if #(
    parameter int unsigned DATAWIDTH_BUS = 32
);
    logic                     IF_REQ_In;
    logic [DATAWIDTH_BUS-1:0] IF_ADDR_In;
    logic                     IF_DONE_Out;
    logic [DATAWIDTH_BUS-1:0] IF_RDATA_Out;
    logic                     DATA_REQ_In;
    logic                     DATA_WE_In;
    logic [DATAWIDTH_BUS-1:0] DATA_ADDR_In;
    logic [DATAWIDTH_BUS-1:0] DATA_WDATA_In;
    logic                     DATA_DONE_Out;
    logic [DATAWIDTH_BUS-1:0] DATA_RDATA_Out;
    logic                     MEM_RD_Out;
    logic                     MEM_WR_Out;
    logic [DATAWIDTH_BUS-1:0] MEM_ADDR_Out;
    logic [DATAWIDTH_BUS-1:0] MEM_WDATA_Out;
    logic [DATAWIDTH_BUS-1:0] MEM_RDATA_In;
    logic                     MEM_ACK_In;
    logic                     BUSY_Out;
    logic                     TIMEOUT_Out;

    modport slave (
        input  IF_REQ_In, IF_ADDR_In, DATA_REQ_In, DATA_WE_In, DATA_ADDR_In,
               DATA_WDATA_In, MEM_RDATA_In, MEM_ACK_In,
        output IF_DONE_Out, IF_RDATA_Out, DATA_DONE_Out, DATA_RDATA_Out,
               MEM_RD_Out, MEM_WR_Out, MEM_ADDR_Out, MEM_WDATA_Out,
               BUSY_Out, TIMEOUT_Out
    );

    modport master (
        output IF_REQ_In, IF_ADDR_In, DATA_REQ_In, DATA_WE_In, DATA_ADDR_In,
               DATA_WDATA_In, MEM_RDATA_In, MEM_ACK_In,
        input  IF_DONE_Out, IF_RDATA_Out, DATA_DONE_Out, DATA_RDATA_Out,
               MEM_RD_Out, MEM_WR_Out, MEM_ADDR_Out, MEM_WDATA_Out,
               BUSY_Out, TIMEOUT_Out
    );
endinterface

// File: rtl/main_memory_arbiter.sv
// Round-robin arbiter/sequencer sharing one main memory port between the
// instruction-fetch path (read-only) and the data path (read/write).
// One transaction in flight: IDLE -> ACCESS -> DONE -> IDLE. An access ends on
// MEM_ACK_In or after TIMEOUT_CYCLES cycles without one.
// Ports:
//   MAIN_MEMORY_ARBITER_CLOCK_50    system clock, rising edge
//   MAIN_MEMORY_ARBITER_RESET_InLow asynchronous active-low reset
//   bus                             requester and memory signals (slave side)
module main_memory_arbiter #(
    parameter int unsigned DATAWIDTH_BUS  = 32,
    parameter int unsigned TIMEOUT_CYCLES = 4,
    parameter int unsigned CNT_W          = 4
) (
    input  logic                  MAIN_MEMORY_ARBITER_CLOCK_50,
    input  logic                  MAIN_MEMORY_ARBITER_RESET_InLow,
    main_memory_arbiter_if.slave  bus
);
    localparam int unsigned DW = DATAWIDTH_BUS;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
    typedef enum logic {OWN_IF, OWN_DATA} owner_t;

    state_t          state_q, state_nxt;
    owner_t          owner_q, last_grant_q, grant_owner;
    logic            grant, finish;
    logic [DW-1:0]   addr_q, wdata_q, if_rdata_q, data_rdata_q;
    logic            we_q, timeout_q;
    logic [CNT_W-1:0] cnt_q;

    // State register
    always_ff @(posedge MAIN_MEMORY_ARBITER_CLOCK_50 or negedge MAIN_MEMORY_ARBITER_RESET_InLow) begin
        if (!MAIN_MEMORY_ARBITER_RESET_InLow) state_q <= S_IDLE;
        else                                  state_q <= state_nxt;
    end

    // Next state, arbitration and access completion
    always_comb begin
        state_nxt   = state_q;
        grant       = 1'b0;
        grant_owner = OWN_IF;
        finish      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.IF_REQ_In || bus.DATA_REQ_In) begin
                    grant = 1'b1;
                    // Contention goes to whoever was not served last
                    if (bus.IF_REQ_In && bus.DATA_REQ_In)
                        grant_owner = (last_grant_q == OWN_DATA) ? OWN_IF : OWN_DATA;
                    else
                        grant_owner = bus.DATA_REQ_In ? OWN_DATA : OWN_IF;
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (bus.MEM_ACK_In || (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                    finish    = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Transaction latch, wait counter and read-data capture
    always_ff @(posedge MAIN_MEMORY_ARBITER_CLOCK_50 or negedge MAIN_MEMORY_ARBITER_RESET_InLow) begin
        if (!MAIN_MEMORY_ARBITER_RESET_InLow) begin
            owner_q      <= OWN_IF;
            last_grant_q <= OWN_DATA;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
            if_rdata_q   <= '0;
            data_rdata_q <= '0;
        end else if (grant) begin
            owner_q      <= grant_owner;
            last_grant_q <= grant_owner;
            addr_q       <= (grant_owner == OWN_DATA) ? bus.DATA_ADDR_In : bus.IF_ADDR_In;
            wdata_q      <= (grant_owner == OWN_DATA) ? bus.DATA_WDATA_In : '0;
            we_q         <= (grant_owner == OWN_DATA) && bus.DATA_WE_In;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
        end else if (state_q == S_ACCESS) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (finish) begin
                timeout_q <= !bus.MEM_ACK_In;
                if (!we_q) begin
                    if (owner_q == OWN_DATA) data_rdata_q <= bus.MEM_RDATA_In;
                    else                     if_rdata_q   <= bus.MEM_RDATA_In;
                end
            end
        end
    end

    // Outputs decoded from registered state only; reset drops strobes at once
    assign bus.MEM_RD_Out     = (state_q == S_ACCESS) && !we_q;
    assign bus.MEM_WR_Out     = (state_q == S_ACCESS) && we_q;
    assign bus.MEM_ADDR_Out   = (state_q == S_ACCESS) ? addr_q : '0;
    assign bus.MEM_WDATA_Out  = ((state_q == S_ACCESS) && we_q) ? wdata_q : '0;
    assign bus.IF_DONE_Out    = (state_q == S_DONE) && (owner_q == OWN_IF);
    assign bus.DATA_DONE_Out  = (state_q == S_DONE) && (owner_q == OWN_DATA);
    assign bus.TIMEOUT_Out    = (state_q == S_DONE) && timeout_q;
    assign bus.BUSY_Out       = (state_q != S_IDLE);
    assign bus.IF_RDATA_Out   = if_rdata_q;
    assign bus.DATA_RDATA_Out = data_rdata_q;
endmodule
